// File: rtl/pedal_pkg.sv
// Shared definitions for the loop/delay engine.
// Contents:
//   MODE_*  : operating mode encodings driven on the mode input
//   ST_*    : sequencer state encodings (IDLE -> RD -> CAP -> WR)
//   sat_add : signed add clamped to a given two's-complement width
package pedal_pkg;

    localparam logic [1:0] MODE_DELAY   = 2'd0;
    localparam logic [1:0] MODE_RECORD  = 2'd1;
    localparam logic [1:0] MODE_PLAY    = 2'd2;
    localparam logic [1:0] MODE_OVERDUB = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_CAP  = 2'd2;
    localparam logic [1:0] ST_WR   = 2'd3;

    // Operands are pre-extended to 64 bits by the caller so that the sum
    // never wraps; the result is clamped to the range of a 'width'-bit
    // signed number and still returned 64 bits wide.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 width
    );
        logic signed [63:0] sum;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sum   = a + b;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (sum > max_v) begin
            return max_v;
        end else if (sum < min_v) begin
            return min_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/sat_scale_add.sv
// Combinational optional-scale and saturating add: o_sum = sat(i_a + term)
// where term is either i_tap itself or (i_tap * i_gain) >>> GAIN_W, with the
// gain read as unsigned Q0.GAIN_W.
// Ports:
//   i_a        : signed addend
//   i_tap      : signed value read back from the SRAM
//   i_gain     : unsigned feedback gain
//   i_use_gain : 1 = scale the tap by the gain, 0 = use the tap as-is
//   o_sum      : saturated result
module sat_scale_add
    import pedal_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int GAIN_W = 8
) (
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_tap,
    input  logic        [GAIN_W-1:0] i_gain,
    input  logic                     i_use_gain,
    output logic signed [DATA_W-1:0] o_sum
);

    // One extra bit keeps the unsigned gain positive in the signed product.
    localparam int PROD_W = DATA_W + GAIN_W + 1;

    logic signed [PROD_W-1:0] w_tap_x;
    logic signed [PROD_W-1:0] w_gain_x;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_term;
    logic signed [63:0]       w_a_64;
    logic signed [63:0]       w_term_64;

    assign w_tap_x  = {{(GAIN_W+1){i_tap[DATA_W-1]}}, i_tap};
    assign w_gain_x = {{(DATA_W+1){1'b0}}, i_gain};
    assign w_prod   = w_tap_x * w_gain_x;
    // Full-precision product, then arithmetic shift (rounds toward -inf).
    assign w_term   = i_use_gain ? (w_prod >>> GAIN_W) : w_tap_x;

    assign w_a_64    = {{(64-DATA_W){i_a[DATA_W-1]}}, i_a};
    assign w_term_64 = {{(64-PROD_W){w_term[PROD_W-1]}}, w_term};
    assign o_sum     = DATA_W'(sat_add(w_a_64, w_term_64, DATA_W));

endmodule

// File: rtl/loop_delay_engine.sv
// Single-SRAM audio engine: feedback delay, loop recorder, loop player and
// overdub looper. Each accepted sample runs a fixed RD/CAP/WR sequence.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   sample_valid      : input strobe, accepted only while idle
//   sample_in         : signed input sample
//   mode              : 0 delay, 1 record, 2 play, 3 overdub (latched on accept)
//   delay_len, fb_gain: delay length in samples and feedback gain (delay mode)
//   sample_out(_valid): processed sample and its one-cycle pulse
//   busy, overrun     : sequence in progress, sticky strobe-while-busy flag
//   loop_len          : number of recorded samples
//   mem_*             : SRAM macro interface (active-low csb/web), mem_dout
//                       valid the cycle after a read
//   dbg_state         : current sequencer state
// Handshake: sample_valid is a single-cycle strobe with no ready; a strobe
// is consumed only when busy is low, otherwise it is dropped and flagged.
module loop_delay_engine
    import pedal_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int GAIN_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic        [1:0]        mode,
    input  logic        [ADDR_W-1:0] delay_len,
    input  logic        [GAIN_W-1:0] fb_gain,
    output logic signed [DATA_W-1:0] sample_out,
    output logic                     sample_out_valid,
    output logic                     busy,
    output logic                     overrun,
    output logic        [ADDR_W:0]   loop_len,
    output logic                     mem_csb,
    output logic                     mem_web,
    output logic        [ADDR_W-1:0] mem_addr,
    output logic signed [DATA_W-1:0] mem_din,
    input  logic signed [DATA_W-1:0] mem_dout,
    output logic        [1:0]        dbg_state
);

    localparam logic [ADDR_W:0] LEN_FULL = {1'b1, {ADDR_W{1'b0}}};

    logic        [1:0]        r_state;
    logic        [1:0]        r_mode;
    logic        [1:0]        r_prev_mode;
    logic signed [DATA_W-1:0] r_sample;
    logic signed [DATA_W-1:0] r_tap;
    logic signed [DATA_W-1:0] r_out;
    logic                     r_out_valid;
    logic                     r_overrun;
    logic        [ADDR_W-1:0] r_wr_ptr;
    logic        [ADDR_W-1:0] r_play_ptr;
    logic        [ADDR_W:0]   r_loop_len;

    logic                     w_loop_empty;
    logic                     w_rec_full;
    logic                     w_is_loop_mode;
    logic                     w_rd_en;
    logic                     w_wr_en;
    logic        [ADDR_W-1:0] w_rd_addr;
    logic        [ADDR_W-1:0] w_wr_addr;
    logic signed [DATA_W-1:0] w_cap_tap;
    logic signed [DATA_W-1:0] w_out;
    logic signed [DATA_W-1:0] w_wval;
    logic        [ADDR_W:0]   w_play_inc;
    logic        [ADDR_W-1:0] w_play_next;

    assign w_loop_empty   = (r_loop_len == '0);
    assign w_rec_full     = (r_loop_len == LEN_FULL);
    assign w_is_loop_mode = (r_mode == MODE_PLAY) || (r_mode == MODE_OVERDUB);
    assign w_rd_en = (r_mode == MODE_DELAY) || (w_is_loop_mode && !w_loop_empty);
    assign w_wr_en = (r_mode == MODE_DELAY)
                  || ((r_mode == MODE_RECORD) && !w_rec_full)
                  || ((r_mode == MODE_OVERDUB) && !w_loop_empty);

    // Delay taps wrap naturally in ADDR_W bits; delay_len = 0 reads the
    // slot about to be overwritten, i.e. a full DEPTH-sample delay.
    assign w_rd_addr = (r_mode == MODE_DELAY) ? (r_wr_ptr - delay_len) : r_play_ptr;
    assign w_wr_addr = (r_mode == MODE_OVERDUB) ? r_play_ptr : r_wr_ptr;

    // Without a read the tap is zero, so out = sat(in + 0) = in.
    assign w_cap_tap = w_rd_en ? mem_dout : '0;

    assign w_play_inc  = {1'b0, r_play_ptr} + (ADDR_W+1)'(1);
    assign w_play_next = (w_play_inc == r_loop_len) ? '0 : w_play_inc[ADDR_W-1:0];

    sat_scale_add #(.DATA_W(DATA_W), .GAIN_W(GAIN_W)) u_out_path (
        .i_a        (r_sample),
        .i_tap      (w_cap_tap),
        .i_gain     (fb_gain),
        .i_use_gain (1'b0),
        .o_sum      (w_out)
    );

    // Delay writes back the gain-scaled tap; overdub writes sat(tap + in),
    // which equals the value already sent out; record writes in (tap = 0).
    sat_scale_add #(.DATA_W(DATA_W), .GAIN_W(GAIN_W)) u_wval_path (
        .i_a        (r_sample),
        .i_tap      (r_tap),
        .i_gain     (fb_gain),
        .i_use_gain (r_mode == MODE_DELAY),
        .o_sum      (w_wval)
    );

    // SRAM strobes are gated by rst_n so that a reset asserted during WR
    // never lets the macro commit the abandoned sample.
    always_comb begin
        mem_csb  = 1'b1;
        mem_web  = 1'b1;
        mem_addr = '0;
        mem_din  = '0;
        if (rst_n) begin
            case (r_state)
                ST_RD: begin
                    if (w_rd_en) begin
                        mem_csb  = 1'b0;
                        mem_addr = w_rd_addr;
                    end
                end
                ST_WR: begin
                    if (w_wr_en) begin
                        mem_csb  = 1'b0;
                        mem_web  = 1'b0;
                        mem_addr = w_wr_addr;
                        mem_din  = w_wval;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_DELAY;
            r_prev_mode <= MODE_DELAY;
            r_sample    <= '0;
            r_tap       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_wr_ptr    <= '0;
            r_play_ptr  <= '0;
            r_loop_len  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (sample_valid && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (sample_valid) begin
                        r_state     <= ST_RD;
                        r_sample    <= sample_in;
                        r_mode      <= mode;
                        r_prev_mode <= mode;
                        if ((mode == MODE_RECORD) && (r_prev_mode != MODE_RECORD)) begin
                            r_wr_ptr   <= '0;
                            r_loop_len <= '0;
                        end
                        if (((mode == MODE_PLAY) || (mode == MODE_OVERDUB))
                            && (r_prev_mode == MODE_RECORD)) begin
                            r_play_ptr <= '0;
                        end
                    end
                end
                ST_RD: begin
                    r_state <= ST_CAP;
                end
                ST_CAP: begin
                    // Output is formed here so it is presented during WR.
                    r_state     <= ST_WR;
                    r_tap       <= w_cap_tap;
                    r_out       <= w_out;
                    r_out_valid <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    case (r_mode)
                        MODE_DELAY: r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                        MODE_RECORD: begin
                            if (!w_rec_full) begin
                                r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
                                r_loop_len <= r_loop_len + (ADDR_W+1)'(1);
                            end
                        end
                        default: begin
                            if (!w_loop_empty) begin
                                r_play_ptr <= w_play_next;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    assign sample_out       = r_out;
    assign sample_out_valid = r_out_valid;
    assign busy             = (r_state != ST_IDLE);
    assign overrun          = r_overrun;
    assign loop_len         = r_loop_len;
    assign dbg_state        = r_state;

endmodule

// File: tb/tb_loop_delay_engine.sv
// Directed bench for loop_delay_engine with a behavioural SRAM model.
module tb_loop_delay_engine;
    import pedal_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int GAIN_W = 8;

    logic                     clk;
    logic                     rst_n;
    logic                     sample_valid;
    logic signed [DATA_W-1:0] sample_in;
    logic        [1:0]        mode;
    logic        [ADDR_W-1:0] delay_len;
    logic        [GAIN_W-1:0] fb_gain;
    logic signed [DATA_W-1:0] sample_out;
    logic                     sample_out_valid;
    logic                     busy;
    logic                     overrun;
    logic        [ADDR_W:0]   loop_len;
    logic                     mem_csb;
    logic                     mem_web;
    logic        [ADDR_W-1:0] mem_addr;
    logic signed [DATA_W-1:0] mem_din;
    logic signed [DATA_W-1:0] mem_dout;
    logic        [1:0]        dbg_state;

    logic                     clr_mem;
    logic signed [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];

    int tests_run;
    int tests_failed;

    logic signed [DATA_W-1:0] got;
    logic        [3:0]        vld;
    logic        [3:0]        csb_lo;
    logic                     wr_web;
    logic signed [DATA_W-1:0] wr_din;

    loop_delay_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .GAIN_W(GAIN_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sample_valid     (sample_valid),
        .sample_in        (sample_in),
        .mode             (mode),
        .delay_len        (delay_len),
        .fb_gain          (fb_gain),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .busy             (busy),
        .overrun          (overrun),
        .loop_len         (loop_len),
        .mem_csb          (mem_csb),
        .mem_web          (mem_web),
        .mem_addr         (mem_addr),
        .mem_din          (mem_din),
        .mem_dout         (mem_dout),
        .dbg_state        (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM model: read data appears the cycle after the read.
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < (1 << ADDR_W); i++) sram[i] <= '0;
            mem_dout <= '0;
        end else if (!mem_csb) begin
            if (!mem_web) sram[mem_addr] <= mem_din;
            else          mem_dout <= sram[mem_addr];
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one strobe and snapshots RD, CAP, WR and the following idle
    // cycle (bit k of vld/csb_lo). extra_k >= 0 re-raises the strobe in
    // snapshot cycle extra_k to exercise the busy path.
    task automatic run_sample(input logic signed [DATA_W-1:0] din, input logic [1:0] md,
                              input int extra_k,
                              output logic signed [DATA_W-1:0] dout, output logic [3:0] v,
                              output logic [3:0] c, output logic web_o,
                              output logic signed [DATA_W-1:0] din_o);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = din;
        mode         = md;
        dout  = '0;
        web_o = 1'b1;
        din_o = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            sample_valid = (k == extra_k);
            v[k] = sample_out_valid;
            c[k] = ~mem_csb;
            if (k == 2) begin
                dout  = sample_out;
                web_o = mem_web;
                din_o = mem_din;
            end
        end
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({sample_out, sample_out_valid, busy, overrun} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got out=%0d vld=%b busy=%b ovr=%b, expected all 0",
                     sample_out, sample_out_valid, busy, overrun);
        end
        tests_run++;
        if ({mem_csb, mem_web, mem_addr, mem_din} !== {1'b1, 1'b1, 10'd0, 16'd0}) begin
            tests_failed++;
            $display("FAIL reset_mem: got csb=%b web=%b addr=%0d din=%0d, expected 1 1 0 0",
                     mem_csb, mem_web, mem_addr, mem_din);
        end
        tests_run++;
        if (loop_len !== '0 || dbg_state !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got loop_len=%0d state=%0d, expected 0 0", loop_len, dbg_state);
        end
        clr_mem = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic test_reset_mid_wr();
        @(negedge clk);
        delay_len    = 10'd3;
        fb_gain      = '0;
        sample_valid = 1'b1;
        sample_in    = 16'sd100;
        mode         = MODE_DELAY;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (dbg_state !== ST_WR) begin
            tests_failed++;
            $display("FAIL midwr_state: got %0d expected %0d", dbg_state, ST_WR);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (mem_web !== 1'b1 || mem_csb !== 1'b1) begin
            tests_failed++;
            $display("FAIL midwr_no_write: got web=%b csb=%b expected 1 1", mem_web, mem_csb);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || sample_out !== '0 || sample_out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midwr_after: got busy=%b out=%0d vld=%b expected 0 0 0",
                     busy, sample_out, sample_out_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_delay();
        logic signed [DATA_W-1:0] exp_o [0:4];
        exp_o = '{16'sd1, 16'sd2, 16'sd3, 16'sd5, 16'sd7};
        delay_len = 10'd3;
        fb_gain   = '0;
        for (int i = 0; i < 5; i++) begin
            run_sample(16'(i + 1), MODE_DELAY, -1, got, vld, csb_lo, wr_web, wr_din);
            tests_run++;
            if (got !== exp_o[i]) begin
                tests_failed++;
                $display("FAIL delay_out[%0d]: got %0d expected %0d", i, got, exp_o[i]);
            end
            tests_run++;
            if (vld !== 4'b0100 || csb_lo !== 4'b0101) begin
                tests_failed++;
                $display("FAIL delay_timing[%0d]: got vld=%b csb_lo=%b expected 0100 0101", i, vld, csb_lo);
            end
        end
    endtask

    task automatic test_delay_sat();
        logic signed [DATA_W-1:0] max_s;
        logic signed [DATA_W-1:0] min_s;
        max_s = 16'sh7FFF;
        min_s = 16'sh8000;
        delay_len = 10'd1;
        fb_gain   = 8'd128;
        do_reset();
        run_sample(max_s, MODE_DELAY, -1, got, vld, csb_lo, wr_web, wr_din);
        run_sample(max_s, MODE_DELAY, -1, got, vld, csb_lo, wr_web, wr_din);
        tests_run++;
        if (got !== max_s || wr_web !== 1'b0 || wr_din !== max_s) begin
            tests_failed++;
            $display("FAIL sat_pos: got out=%0d web=%b din=%0d expected 32767 0 32767", got, wr_web, wr_din);
        end
        do_reset();
        run_sample(min_s, MODE_DELAY, -1, got, vld, csb_lo, wr_web, wr_din);
        tests_run++;
        if (got !== min_s || wr_din !== min_s) begin
            tests_failed++;
            $display("FAIL sat_neg_first: got out=%0d din=%0d expected -32768 -32768", got, wr_din);
        end
        run_sample(min_s, MODE_DELAY, -1, got, vld, csb_lo, wr_web, wr_din);
        tests_run++;
        if (got !== min_s || wr_din !== min_s) begin
            tests_failed++;
            $display("FAIL sat_neg: got out=%0d din=%0d expected -32768 -32768", got, wr_din);
        end
    endtask

    task automatic record_three();
        logic signed [DATA_W-1:0] rec [0:2];
        rec = '{16'sd10, 16'sd20, 16'sd30};
        for (int i = 0; i < 3; i++) begin
            run_sample(rec[i], MODE_RECORD, -1, got, vld, csb_lo, wr_web, wr_din);
            tests_run++;
            if (got !== rec[i] || csb_lo !== 4'b0100 || wr_din !== rec[i]) begin
                tests_failed++;
                $display("FAIL record[%0d]: got out=%0d csb_lo=%b din=%0d expected %0d 0100 %0d",
                         i, got, csb_lo, wr_din, rec[i], rec[i]);
            end
        end
        tests_run++;
        if (loop_len !== 11'd3) begin
            tests_failed++;
            $display("FAIL loop_len: got %0d expected 3", loop_len);
        end
    endtask

    task automatic test_record_play();
        logic signed [DATA_W-1:0] exp_p [0:6];
        exp_p = '{16'sd10, 16'sd20, 16'sd30, 16'sd10, 16'sd20, 16'sd30, 16'sd10};
        do_reset();
        record_three();
        for (int i = 0; i < 7; i++) begin
            run_sample(16'sd0, MODE_PLAY, -1, got, vld, csb_lo, wr_web, wr_din);
            tests_run++;
            if (got !== exp_p[i] || csb_lo !== 4'b0001) begin
                tests_failed++;
                $display("FAIL play[%0d]: got out=%0d csb_lo=%b expected %0d 0001", i, got, csb_lo, exp_p[i]);
            end
        end
    endtask

    task automatic test_overdub();
        logic signed [DATA_W-1:0] exp_o [0:2];
        exp_o = '{16'sd11, 16'sd21, 16'sd31};
        record_three();
        for (int i = 0; i < 3; i++) begin
            run_sample(16'sd1, MODE_OVERDUB, -1, got, vld, csb_lo, wr_web, wr_din);
            tests_run++;
            if (got !== exp_o[i] || wr_web !== 1'b0 || wr_din !== exp_o[i]) begin
                tests_failed++;
                $display("FAIL overdub[%0d]: got out=%0d web=%b din=%0d expected %0d 0 %0d",
                         i, got, wr_web, wr_din, exp_o[i], exp_o[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            run_sample(16'sd0, MODE_PLAY, -1, got, vld, csb_lo, wr_web, wr_din);
            tests_run++;
            if (got !== exp_o[i]) begin
                tests_failed++;
                $display("FAIL overdub_play[%0d]: got %0d expected %0d", i, got, exp_o[i]);
            end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        delay_len = 10'd3;
        fb_gain   = '0;
        run_sample(16'sd5, MODE_DELAY, 1, got, vld, csb_lo, wr_web, wr_din);
        tests_run++;
        if (vld !== 4'b0100 || overrun !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_cap: got vld=%b ovr=%b busy=%b expected 0100 1 0", vld, overrun, busy);
        end
        do_reset();
        run_sample(16'sd6, MODE_DELAY, 2, got, vld, csb_lo, wr_web, wr_din);
        tests_run++;
        if (vld !== 4'b0100 || overrun !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_wr: got vld=%b ovr=%b busy=%b expected 0100 1 0", vld, overrun, busy);
        end
        run_sample(16'sd7, MODE_DELAY, -1, got, vld, csb_lo, wr_web, wr_din);
        tests_run++;
        if (overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_sticky: got %b expected 1", overrun);
        end
        do_reset();
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_clear: got %b expected 0", overrun);
        end
    endtask

    task automatic test_play_empty();
        do_reset();
        run_sample(16'sd55, MODE_PLAY, -1, got, vld, csb_lo, wr_web, wr_din);
        tests_run++;
        if (got !== 16'sd55 || csb_lo !== 4'b0000 || vld !== 4'b0100) begin
            tests_failed++;
            $display("FAIL play_empty: got out=%0d csb_lo=%b vld=%b expected 55 0000 0100", got, csb_lo, vld);
        end
        run_sample(-16'sd9, MODE_OVERDUB, -1, got, vld, csb_lo, wr_web, wr_din);
        tests_run++;
        if (got !== -16'sd9 || csb_lo !== 4'b0000) begin
            tests_failed++;
            $display("FAIL overdub_empty: got out=%0d csb_lo=%b expected -9 0000", got, csb_lo);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        clr_mem      = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        mode         = MODE_DELAY;
        delay_len    = 10'd3;
        fb_gain      = '0;

        test_reset();
        test_reset_mid_wr();
        test_delay();
        test_delay_sat();
        test_record_play();
        test_overdub();
        test_overrun();
        test_play_empty();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
